// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Fetch-stage bus bundle: instruction memory handshake, decoded
//               instruction fields, controller branch inputs and interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       instr_valid;
    logic [3:0] opcode;
    logic [1:0] rd_a;
    logic [1:0] rs_a;
    logic [7:0] pc;
    logic       jmp_en;
    logic       je_en;
    logic       ret;
    logic       flag;
    logic [7:0] jmp_target;
    logic       int_req;
    logic [7:0] int_vector;
    logic       int_ack;

    // master: the fetch unit itself
    modport master (
        output imem_req, imem_addr, instr_valid, opcode, rd_a, rs_a, pc, int_ack,
        input  imem_ack, imem_data, jmp_en, je_en, ret, flag, jmp_target,
               int_req, int_vector
    );

    // slave: memory, controller and interrupt source
    modport slave (
        input  imem_req, imem_addr, instr_valid, opcode, rd_a, rs_a, pc, int_ack,
        output imem_ack, imem_data, jmp_en, je_en, ret, flag, jmp_target,
               int_req, int_vector
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch / PC stage with single-level interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  wire logic          clock,
    input  wire logic          reset,
    fetch_unit_if.master       bus
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pc;
    logic [7:0] w_pc_nxt;
    logic [7:0] r_ir;
    logic [7:0] w_ir_nxt;
    logic [7:0] r_epc;
    logic [7:0] w_epc_nxt;
    logic       r_ie;
    logic       w_ie_nxt;
    logic       r_int_ack;
    logic       w_take_int;
    logic [7:0] w_npc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_ir      <= 8'h00;
            r_epc     <= 8'h00;
            r_ie      <= 1'b1;
            r_int_ack <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ir      <= w_ir_nxt;
            r_epc     <= w_epc_nxt;
            r_ie      <= w_ie_nxt;
            r_int_ack <= w_take_int;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_epc_nxt   = r_epc;
        w_ie_nxt    = r_ie;
        w_take_int  = 1'b0;
        w_npc       = r_pc + 8'd1;

        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    w_ir_nxt    = bus.imem_data;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.ret) begin
                    w_npc    = r_epc;
                    w_ie_nxt = 1'b1;
                end else if (bus.jmp_en) begin
                    w_npc = bus.jmp_target;
                end else if (bus.je_en && bus.flag) begin
                    w_npc = bus.jmp_target;
                end

                // Uses the pre-update ie, so a ret never admits an interrupt
                // in its own EXEC cycle.
                w_take_int = bus.int_req && r_ie;
                if (w_take_int) begin
                    w_epc_nxt = w_npc;
                    w_pc_nxt  = bus.int_vector;
                    w_ie_nxt  = 1'b0;
                end else begin
                    w_pc_nxt = w_npc;
                end
                w_state_nxt = S_FETCH;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = (r_state == S_EXEC);
    assign bus.opcode      = r_ir[7:4];
    assign bus.rd_a        = r_ir[3:2];
    assign bus.rs_a        = r_ir[1:0];
    assign bus.pc          = r_pc;
    assign bus.int_ack     = r_int_ack;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_pc = 8'h00;

    always #5 clock = ~clock;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(8'h00)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Entered at a negedge in the first FETCH cycle; leaves at the negedge of
    // the next instruction's first FETCH cycle.
    task automatic run_instr(input logic [7:0] instr, input int waits,
                             input logic jmp, input logic je, input logic flg,
                             input logic rt, input logic [7:0] tgt,
                             input logic [7:0] exp_next, input logic exp_ack);
        for (int i = 0; i < waits; i++) begin
            check_val("wait_req", bus.imem_req, 1'b1);
            check_val("wait_addr", bus.imem_addr, exp_pc);
            bus.imem_ack   = 1'b0;
            bus.jmp_en     = 1'b1;
            bus.ret        = 1'b1;
            bus.jmp_target = 8'h55;
            @(negedge clock);
        end
        check_val("fetch_req", bus.imem_req, 1'b1);
        check_val("fetch_addr", bus.imem_addr, exp_pc);
        check_val("fetch_valid", bus.instr_valid, 1'b0);
        bus.jmp_en    = 1'b0;
        bus.ret       = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_data = instr;
        @(negedge clock);
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'hA5;
        check_val("exec_valid", bus.instr_valid, 1'b1);
        check_val("exec_req", bus.imem_req, 1'b0);
        check_val("exec_opcode", bus.opcode, instr[7:4]);
        check_val("exec_rd", bus.rd_a, instr[3:2]);
        check_val("exec_rs", bus.rs_a, instr[1:0]);
        check_val("exec_int_ack", bus.int_ack, 1'b0);
        bus.jmp_en     = jmp;
        bus.je_en      = je;
        bus.flag       = flg;
        bus.ret        = rt;
        bus.jmp_target = tgt;
        @(negedge clock);
        bus.jmp_en     = 1'b0;
        bus.je_en      = 1'b0;
        bus.flag       = 1'b0;
        bus.ret        = 1'b0;
        check_val("next_addr", bus.imem_addr, exp_next);
        check_val("next_int_ack", bus.int_ack, exp_ack);
        exp_pc = exp_next;
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_data  = 8'h00;
        bus.jmp_en     = 1'b0;
        bus.je_en      = 1'b0;
        bus.ret        = 1'b0;
        bus.flag       = 1'b0;
        bus.jmp_target = 8'h00;
        bus.int_req    = 1'b0;
        bus.int_vector = 8'hF0;

        @(negedge clock);
        @(negedge clock);
        check_val("rst_req", bus.imem_req, 1'b0);
        check_val("rst_valid", bus.instr_valid, 1'b0);
        check_val("rst_int_ack", bus.int_ack, 1'b0);
        check_val("rst_pc", bus.pc, 8'h00);
        check_val("rst_opcode", bus.opcode, 4'h0);
        reset = 1'b1;
        check_val("boot_req", bus.imem_req, 1'b0);
        @(negedge clock);
        check_val("first_req", bus.imem_req, 1'b1);

        // zero-wait sequential fetch and wrap
        run_instr(8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0);
        run_instr(8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h02, 0);
        run_instr(8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h03, 0);
        run_instr(8'h00, 0, 1, 0, 0, 0, 8'hFF, 8'hFF, 0);
        run_instr(8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);

        // wait-stated fetch with field decode
        run_instr(8'h1B, 3, 0, 0, 0, 0, 8'h00, 8'h01, 0);

        // branches
        run_instr(8'h20, 0, 0, 1, 0, 0, 8'h40, 8'h02, 0);
        run_instr(8'h20, 1, 0, 1, 1, 0, 8'h40, 8'h40, 0);
        run_instr(8'h30, 0, 1, 0, 0, 0, 8'h80, 8'h80, 0);
        run_instr(8'h30, 0, 1, 0, 0, 0, 8'h10, 8'h10, 0);

        // interrupt entry, hold-off, ret with pending request, re-entry
        bus.int_req = 1'b1;
        run_instr(8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hF0, 1);
        run_instr(8'h00, 1, 0, 0, 0, 0, 8'h00, 8'hF1, 0);
        run_instr(8'hC0, 0, 0, 0, 0, 1, 8'h00, 8'h11, 0);
        run_instr(8'h00, 0, 0, 0, 0, 0, 8'h00, 8'hF0, 1);
        bus.int_req = 1'b0;
        run_instr(8'hC0, 1, 0, 0, 0, 1, 8'h00, 8'h12, 0);

        // reset during a FETCH wait with ack in the reset cycle
        check_val("pre_rst_req", bus.imem_req, 1'b1);
        reset         = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hFF;
        @(negedge clock);
        bus.imem_ack  = 1'b0;
        check_val("mid_rst_req", bus.imem_req, 1'b0);
        check_val("mid_rst_valid", bus.instr_valid, 1'b0);
        check_val("mid_rst_opcode", bus.opcode, 4'h0);
        check_val("mid_rst_pc", bus.pc, 8'h00);
        reset = 1'b1;
        @(negedge clock);
        check_val("restart_req", bus.imem_req, 1'b1);
        exp_pc = 8'h00;
        run_instr(8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
